// File: rtl/ctrl_word_pipe.sv
// ctrl_word_pipe: ID/EX, EX/MEM, MEM/WB control-word registers with stall, flush and load-use policy.
// Define CTRL_PIPE_COMMIT_CNT_EN to add the 64-bit retired-instruction counter and commit_count port.
package rv32i_types;
  typedef logic [4:0] rv32i_reg_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alumux1_sel;
    logic [2:0] alumux2_sel;
    logic [3:0] regfilemux_sel;
    logic [2:0] cmp_op;
    logic       cmpmux_sel;
    logic       load_regfile;
    logic       datacache_mem_read;
    logic       datacache_mem_write;
    logic [2:0] mem_funct3;
    logic       is_branch;
    logic       is_jump;
    logic       trap;
  } ctrl_word_t;

  typedef struct packed {
    ctrl_word_t ctrl;
    logic       valid;
    rv32i_reg_t rd;
  } stage_t;
endpackage

module ctrl_word_pipe
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  ctrl_word_t id_ctrl,
  input  logic       id_valid,
  input  logic [4:0] id_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       mem_stall,
  input  logic       br_flush,
  output logic       id_stall,
  output ctrl_word_t ex_ctrl,
  output ctrl_word_t mem_ctrl,
  output ctrl_word_t wb_ctrl,
  output logic       ex_valid,
  output logic       mem_valid,
  output logic       wb_valid,
  output logic [4:0] ex_rd,
  output logic [4:0] mem_rd,
  output logic [4:0] wb_rd
`ifdef CTRL_PIPE_COMMIT_CNT_EN
  ,
  output logic [63:0] commit_count
`endif
);

  stage_t r_ex;
  stage_t r_mem;
  stage_t r_wb;
  stage_t w_id_stage;
  logic   w_load_use;
  logic   w_src_match;

  // An invalid decode slot always becomes an all-zero bubble, whatever ctrl/rd carry.
  always_comb begin
    w_id_stage = '0;
    if (id_valid) begin
      w_id_stage.ctrl  = id_ctrl;
      w_id_stage.valid = 1'b1;
      w_id_stage.rd    = id_rd;
    end
  end

  // Both sources are compared even for formats without rs2: a spurious bubble is harmless.
  assign w_src_match = (r_ex.rd == id_rs1) | (r_ex.rd == id_rs2);
  assign w_load_use  = r_ex.valid & r_ex.ctrl.datacache_mem_read & (r_ex.rd != 5'd0)
                     & id_valid & w_src_match;
  assign id_stall    = mem_stall | (w_load_use & ~br_flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!mem_stall) begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (br_flush || w_load_use) begin
        r_ex <= '0;
      end else begin
        r_ex <= w_id_stage;
      end
    end
  end

  assign ex_ctrl   = r_ex.ctrl;
  assign ex_valid  = r_ex.valid;
  assign ex_rd     = r_ex.rd;
  assign mem_ctrl  = r_mem.ctrl;
  assign mem_valid = r_mem.valid;
  assign mem_rd    = r_mem.rd;
  assign wb_ctrl   = r_wb.ctrl;
  assign wb_valid  = r_wb.valid;
  assign wb_rd     = r_wb.rd;

`ifdef CTRL_PIPE_COMMIT_CNT_EN
  logic [63:0] r_commit_count;

  // An instruction retires on the edge it leaves WB; a stalled WB has not retired yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_count <= '0;
    end else if (r_wb.valid && !mem_stall) begin
      r_commit_count <= r_commit_count + 64'd1;
    end
  end

  assign commit_count = r_commit_count;
`endif

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// Directed bench for ctrl_word_pipe: scoreboard checks WB order/content, inline checks cover timing and hazards.
module tb_ctrl_word_pipe;
  import rv32i_types::*;

  logic       clk = 1'b0;
  logic       rst;
  ctrl_word_t id_ctrl;
  logic       id_valid;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       mem_stall, br_flush;
  logic       id_stall;
  ctrl_word_t ex_ctrl, mem_ctrl, wb_ctrl;
  logic       ex_valid, mem_valid, wb_valid;
  logic [4:0] ex_rd, mem_rd, wb_rd;
`ifdef CTRL_PIPE_COMMIT_CNT_EN
  logic [63:0] commit_count;
  logic [63:0] exp_commit;
`endif

  typedef struct {
    ctrl_word_t ctrl;
    logic [4:0] rd;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        checks = 0;
  int        errors = 0;
  logic      stall_prev = 1'b0;

  ctrl_word_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .id_ctrl   (id_ctrl),
    .id_valid  (id_valid),
    .id_rd     (id_rd),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .mem_stall (mem_stall),
    .br_flush  (br_flush),
    .id_stall  (id_stall),
    .ex_ctrl   (ex_ctrl),
    .mem_ctrl  (mem_ctrl),
    .wb_ctrl   (wb_ctrl),
    .ex_valid  (ex_valid),
    .mem_valid (mem_valid),
    .wb_valid  (wb_valid),
    .ex_rd     (ex_rd),
    .mem_rd    (mem_rd),
    .wb_rd     (wb_rd)
`ifdef CTRL_PIPE_COMMIT_CNT_EN
    ,
    .commit_count (commit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_word_t alu_word(input logic [3:0] op);
    ctrl_word_t c;
    c = '0;
    c.alu_op       = op;
    c.load_regfile = 1'b1;
    return c;
  endfunction

  function automatic ctrl_word_t load_word();
    ctrl_word_t c;
    c = '0;
    c.datacache_mem_read = 1'b1;
    c.load_regfile       = 1'b1;
    c.regfilemux_sel     = 4'd3;
    c.alumux2_sel        = 3'd1;
    c.mem_funct3         = 3'b010;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ctrl_word_t c, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit expect_retire);
    id_ctrl  = c;
    id_valid = 1'b1;
    id_rd    = rd;
    id_rs1   = rs1;
    id_rs2   = rs2;
    if (expect_retire) sb.push_back('{c, rd});
  endtask

  // Garbage ctrl/rd with id_valid low must still enter the pipe as a zero bubble.
  task automatic idle();
    id_ctrl  = alu_word(4'hf);
    id_valid = 1'b0;
    id_rd    = 5'd31;
    id_rs1   = 5'd0;
    id_rs2   = 5'd0;
  endtask

  always @(posedge clk) stall_prev <= mem_stall;

`ifdef CTRL_PIPE_COMMIT_CNT_EN
  always @(posedge clk or posedge rst) begin
    if (rst) exp_commit <= '0;
    else if (wb_valid && !mem_stall) exp_commit <= exp_commit + 64'd1;
  end
`endif

  // A fresh WB entry appears after every edge that was not stalled.
  always @(negedge clk) begin
    if (!rst && wb_valid && !stall_prev) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        sb_entry_t e;
        e = sb.pop_front();
        $display("WB retire rd=%0d ctrl=%0h expected rd=%0d ctrl=%0h", wb_rd, wb_ctrl, e.rd, e.ctrl);
        chk("sb_wb_ctrl", 64'(wb_ctrl), 64'(e.ctrl));
        chk("sb_wb_rd", 64'(wb_rd), 64'(e.rd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    mem_stall = 1'b0;
    br_flush  = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_id_stall_lo", 64'(id_stall), 64'd0);
    mem_stall = 1'b1;
    #1;
    chk("rst_id_stall_hi", 64'(id_stall), 64'd1);
    mem_stall = 1'b0;
`ifdef CTRL_PIPE_COMMIT_CNT_EN
    chk("rst_count", commit_count, 64'd0);
`endif
    #1;
    rst = 1'b0;

    // Straight-line: rd=t accepted on edge t, visible on WB after edge t+2.
    for (int t = 1; t <= 7; t++) begin
      if (t <= 4) issue(alu_word(4'(t)), 5'(t), 5'(t - 1), 5'd0, 1'b1);
      else idle();
      #1;
      chk("sl_id_stall", 64'(id_stall), 64'd0);
      tick();
      $display("straight t=%0d ex_rd=%0d wb_rd=%0d wb_valid=%0b", t, ex_rd, wb_rd, wb_valid);
      chk("sl_ex_rd", 64'(ex_rd), (t <= 4) ? 64'(t) : 64'd0);
      chk("sl_ex_valid", 64'(ex_valid), (t <= 4) ? 64'd1 : 64'd0);
      chk("sl_wb_rd", 64'(wb_rd), (t >= 3 && t <= 6) ? 64'(t - 2) : 64'd0);
      chk("sl_wb_valid", 64'(wb_valid), (t >= 3 && t <= 6) ? 64'd1 : 64'd0);
    end
`ifdef CTRL_PIPE_COMMIT_CNT_EN
    chk("sl_count", commit_count, 64'd4);
`endif

    // Load-use on rs1: one bubble, then the consumer enters EX.
    issue(load_word(), 5'd5, 5'd1, 5'd2, 1'b1);
    #1;
    chk("lu_pre_stall", 64'(id_stall), 64'd0);
    tick();
    chk("lu_ex_rd", 64'(ex_rd), 64'd5);
    chk("lu_ex_ctrl", 64'(ex_ctrl), 64'(load_word()));
    issue(alu_word(4'd6), 5'd6, 5'd5, 5'd0, 1'b1);
    #1;
    chk("lu_id_stall", 64'(id_stall), 64'd1);
    tick();
    $display("loaduse bubble ex_valid=%0b mem_rd=%0d id_stall=%0b", ex_valid, mem_rd, id_stall);
    chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu_bubble_ctrl", 64'(ex_ctrl), 64'd0);
    chk("lu_mem_rd", 64'(mem_rd), 64'd5);
    chk("lu_stall_drop", 64'(id_stall), 64'd0);
    tick();
    chk("lu_add_ex_rd", 64'(ex_rd), 64'd6);
    chk("lu_add_ex_valid", 64'(ex_valid), 64'd1);
    chk("lu_mem_bubble", 64'(mem_valid), 64'd0);
    chk("lu_wb_rd", 64'(wb_rd), 64'd5);

    // Load to x0 never interlocks.
    issue(load_word(), 5'd0, 5'd3, 5'd0, 1'b1);
    tick();
    issue(alu_word(4'd7), 5'd7, 5'd0, 5'd0, 1'b1);
    #1;
    chk("lu0_id_stall", 64'(id_stall), 64'd0);
    tick();
    chk("lu0_ex_rd", 64'(ex_rd), 64'd7);
    chk("lu0_mem_valid", 64'(mem_valid), 64'd1);
    chk("lu0_mem_rd", 64'(mem_rd), 64'd0);

    // Load-use on rs2 with a cache stall during the interlock: still exactly one bubble.
    issue(load_word(), 5'd8, 5'd0, 5'd0, 1'b1);
    tick();
    issue(alu_word(4'd9), 5'd9, 5'd1, 5'd8, 1'b1);
    #1;
    chk("lu2_id_stall", 64'(id_stall), 64'd1);
    mem_stall = 1'b1;
    tick();
    chk("lu2_hold_ex_rd", 64'(ex_rd), 64'd8);
    chk("lu2_hold_ex_valid", 64'(ex_valid), 64'd1);
    chk("lu2_hold_stall", 64'(id_stall), 64'd1);
    mem_stall = 1'b0;
    #1;
    chk("lu2_release_stall", 64'(id_stall), 64'd1);
    tick();
    chk("lu2_bubble", 64'(ex_valid), 64'd0);
    chk("lu2_mem_rd", 64'(mem_rd), 64'd8);
    tick();
    chk("lu2_add_ex_rd", 64'(ex_rd), 64'd9);
    chk("lu2_mem_bubble", 64'(mem_valid), 64'd0);
    chk("lu2_wb_rd", 64'(wb_rd), 64'd8);

    // Full pipe frozen by mem_stall for three edges.
    for (int r = 10; r <= 12; r++) begin
      issue(alu_word(4'(r)), 5'(r), 5'd0, 5'd0, 1'b1);
      tick();
    end
    issue(alu_word(4'd13), 5'd13, 5'd0, 5'd0, 1'b1);
    mem_stall = 1'b1;
    #1;
    chk("st_id_stall", 64'(id_stall), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("stall k=%0d ex_rd=%0d mem_rd=%0d wb_rd=%0d", k, ex_rd, mem_rd, wb_rd);
      chk("st_ex_rd", 64'(ex_rd), 64'd12);
      chk("st_mem_rd", 64'(mem_rd), 64'd11);
      chk("st_wb_rd", 64'(wb_rd), 64'd10);
      chk("st_wb_valid", 64'(wb_valid), 64'd1);
      chk("st_id_stall_held", 64'(id_stall), 64'd1);
`ifdef CTRL_PIPE_COMMIT_CNT_EN
      chk("st_count", commit_count, exp_commit);
`endif
    end
    mem_stall = 1'b0;
    tick();
    chk("st_rel_ex_rd", 64'(ex_rd), 64'd13);
    chk("st_rel_mem_rd", 64'(mem_rd), 64'd12);
    chk("st_rel_wb_rd", 64'(wb_rd), 64'd11);

    // Flush coinciding with load-use: flush wins, fetch is not held.
    issue(load_word(), 5'd14, 5'd0, 5'd0, 1'b1);
    tick();
    issue(alu_word(4'd15), 5'd15, 5'd14, 5'd0, 1'b0);
    br_flush = 1'b1;
    #1;
    chk("fl_id_stall", 64'(id_stall), 64'd0);
    tick();
    chk("fl_ex_valid", 64'(ex_valid), 64'd0);
    chk("fl_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("fl_mem_rd", 64'(mem_rd), 64'd14);
    chk("fl_mem_ctrl", 64'(mem_ctrl), 64'(load_word()));
    br_flush = 1'b0;

    // Flush is ignored while stalled; it takes effect on the first unstalled edge.
    issue(alu_word(4'd1), 5'd16, 5'd0, 5'd0, 1'b1);
    tick();
    issue(alu_word(4'd2), 5'd17, 5'd0, 5'd0, 1'b0);
    br_flush  = 1'b1;
    mem_stall = 1'b1;
    tick();
    chk("fs_hold_ex_rd", 64'(ex_rd), 64'd16);
    chk("fs_hold_ex_valid", 64'(ex_valid), 64'd1);
    chk("fs_hold_wb_rd", 64'(wb_rd), 64'd14);
    mem_stall = 1'b0;
    tick();
    chk("fs_ex_valid", 64'(ex_valid), 64'd0);
    chk("fs_mem_rd", 64'(mem_rd), 64'd16);
    br_flush = 1'b0;
    idle();
    repeat (3) tick();
`ifdef CTRL_PIPE_COMMIT_CNT_EN
    chk("drain_count", commit_count, exp_commit);
`endif

    // Asynchronous reset mid-cycle while stalled with a full pipe.
    for (int r = 20; r <= 22; r++) begin
      issue(alu_word(4'(r - 16)), 5'(r), 5'd0, 5'd0, 1'b1);
      tick();
    end
    chk("ar_pre_wb_valid", 64'(wb_valid), 64'd1);
    mem_stall = 1'b1;
    idle();
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    $display("async reset ex_valid=%0b mem_valid=%0b wb_valid=%0b", ex_valid, mem_valid, wb_valid);
    chk("ar_ex_valid", 64'(ex_valid), 64'd0);
    chk("ar_ex_rd", 64'(ex_rd), 64'd0);
    chk("ar_mem_valid", 64'(mem_valid), 64'd0);
    chk("ar_mem_ctrl", 64'(mem_ctrl), 64'd0);
    chk("ar_wb_valid", 64'(wb_valid), 64'd0);
    chk("ar_wb_ctrl", 64'(wb_ctrl), 64'd0);
    chk("ar_wb_rd", 64'(wb_rd), 64'd0);
    chk("ar_id_stall_hi", 64'(id_stall), 64'd1);
`ifdef CTRL_PIPE_COMMIT_CNT_EN
    chk("ar_count", commit_count, 64'd0);
`endif
    mem_stall = 1'b0;
    #1;
    chk("ar_id_stall_lo", 64'(id_stall), 64'd0);
    tick();
    rst = 1'b0;
    issue(alu_word(4'd3), 5'd23, 5'd0, 5'd0, 1'b1);
    tick();
    chk("post_rst_ex_rd", 64'(ex_rd), 64'd23);
    chk("post_rst_mem_valid", 64'(mem_valid), 64'd0);
    idle();
    repeat (4) tick();
`ifdef CTRL_PIPE_COMMIT_CNT_EN
    chk("post_rst_count", commit_count, 64'd1);
`endif
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
